// File: rtl/foc_pkg.sv
// Shared FOC fixed-point constants, Park FSM states and Q1.15 scaling helpers.
// Used by the Park transform and intended for the other current-loop stages.
package foc_pkg;

  localparam int Q15_FRAC_BITS = 15;
  localparam logic signed [15:0] Q15_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q15_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_OUT  = 3'd5
  } park_state_e;

  // Arithmetic shift floors toward minus infinity, then clamp into Q1.15 range.
  function automatic logic signed [15:0] q15_scale_sat(input logic signed [32:0] acc);
    logic signed [32:0] r;
    r = acc >>> Q15_FRAC_BITS;
    if (r > 33'sd32767) begin
      return Q15_MAX;
    end else if (r < -33'sd32768) begin
      return Q15_MIN;
    end else begin
      return r[15:0];
    end
  endfunction

  // Plain two's-complement wrap, bit-compatible with the inverse Park stage.
  function automatic logic signed [15:0] q15_scale_wrap(input logic signed [32:0] acc);
    logic signed [32:0] r;
    r = acc >>> Q15_FRAC_BITS;
    return r[15:0];
  endfunction

endpackage

// File: rtl/park_transform_if.sv
// Start/operand/result bundle of the Park transform; master drives operands,
// slave (the transform) returns the rotor-frame currents.
interface park_transform_if;

  logic               iP_en;
  logic signed [15:0] iSin;
  logic signed [15:0] iCos;
  logic signed [15:0] iIalpha;
  logic signed [15:0] iIbeta;
  logic               oP_done;
  logic               oBusy;
  logic signed [15:0] oId;
  logic signed [15:0] oIq;

  modport master (
    output iP_en, iSin, iCos, iIalpha, iIbeta,
    input  oP_done, oBusy, oId, oIq
  );

  modport slave (
    input  iP_en, iSin, iCos, iIalpha, iIbeta,
    output oP_done, oBusy, oId, oIq
  );

endinterface

// File: rtl/park_mac.sv
// Signed 16x16 multiplier with a registered 33-bit accumulator; clear restarts
// the sum from the new product, sub subtracts instead of adding.
module park_mac (
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               en,
  input  logic               clear,
  input  logic               sub,
  input  logic signed [15:0] mul_a,
  input  logic signed [15:0] mul_b,
  output logic signed [32:0] acc
);

  logic signed [31:0] prod_s;
  logic signed [32:0] base_s;
  logic signed [32:0] next_s;
  logic signed [32:0] acc_r;

  // Product and next accumulator value.
  always_comb begin
    prod_s = mul_a * mul_b;
    if (clear) begin
      base_s = 33'sd0;
    end else begin
      base_s = acc_r;
    end
    if (sub) begin
      next_s = base_s - 33'(prod_s);
    end else begin
      next_s = base_s + 33'(prod_s);
    end
  end

  // Accumulator register, held when not enabled.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      acc_r <= 33'sd0;
    end else if (en) begin
      acc_r <= next_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/park_transform.sv
// Forward Park transform: Id = a*cos + b*sin, Iq = b*cos - a*sin over one shared MAC.
// Define FOC_PARK_SAT_EN to clamp results; otherwise results wrap two's-complement.
module park_transform
  import foc_pkg::*;
(
  input logic             iClk,
  input logic             iRst_n,
  park_transform_if.slave bus
);

  park_state_e        state_r, state_s;
  logic               en_prev_r;
  logic               start_s;
  logic signed [15:0] op_sin_r, op_cos_r, op_ialpha_r, op_ibeta_r;
  logic signed [32:0] acc_d_r;
  logic signed [32:0] mac_acc_s;
  logic               mac_en_s, mac_clr_s, mac_sub_s;
  logic signed [15:0] mul_a_s, mul_b_s;
  logic signed [15:0] res_d_s, res_q_s;
  logic               done_r, busy_r;
  logic signed [15:0] id_r, iq_r;

  assign start_s = ~en_prev_r & bus.iP_en;

  // Sequencing: each M-state feeds one product into the MAC.
  always_comb begin
    state_s   = state_r;
    mac_en_s  = 1'b0;
    mac_clr_s = 1'b0;
    mac_sub_s = 1'b0;
    mul_a_s   = op_ialpha_r;
    mul_b_s   = op_cos_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_M0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_M0: begin
        mac_en_s  = 1'b1;
        mac_clr_s = 1'b1;
        state_s   = ST_M1;
      end
      ST_M1: begin
        mac_en_s = 1'b1;
        mul_a_s  = op_ibeta_r;
        mul_b_s  = op_sin_r;
        state_s  = ST_M2;
      end
      ST_M2: begin
        mac_en_s  = 1'b1;
        mac_clr_s = 1'b1;
        mul_a_s   = op_ibeta_r;
        state_s   = ST_M3;
      end
      ST_M3: begin
        mac_en_s  = 1'b1;
        mac_sub_s = 1'b1;
        mul_b_s   = op_sin_r;
        state_s   = ST_OUT;
      end
      ST_OUT:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  park_mac u_mac (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .en     (mac_en_s),
    .clear  (mac_clr_s),
    .sub    (mac_sub_s),
    .mul_a  (mul_a_s),
    .mul_b  (mul_b_s),
    .acc    (mac_acc_s)
  );

`ifdef FOC_PARK_SAT_EN
  assign res_d_s = q15_scale_sat(acc_d_r);
  assign res_q_s = q15_scale_sat(mac_acc_s);
`else
  assign res_d_s = q15_scale_wrap(acc_d_r);
  assign res_q_s = q15_scale_wrap(mac_acc_s);
`endif

  // State, edge detector, operand latch, d-sum park register and outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r     <= ST_IDLE;
      en_prev_r   <= 1'b0;
      op_sin_r    <= 16'sd0;
      op_cos_r    <= 16'sd0;
      op_ialpha_r <= 16'sd0;
      op_ibeta_r  <= 16'sd0;
      acc_d_r     <= 33'sd0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      id_r        <= 16'sd0;
      iq_r        <= 16'sd0;
    end else begin
      state_r   <= state_s;
      en_prev_r <= bus.iP_en;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= (state_r == ST_OUT);
      if ((state_r == ST_IDLE) && start_s) begin
        op_sin_r    <= bus.iSin;
        op_cos_r    <= bus.iCos;
        op_ialpha_r <= bus.iIalpha;
        op_ibeta_r  <= bus.iIbeta;
      end else begin
        op_sin_r    <= op_sin_r;
        op_cos_r    <= op_cos_r;
        op_ialpha_r <= op_ialpha_r;
        op_ibeta_r  <= op_ibeta_r;
      end
      // The MAC is reused for the q-sum in M2, so the finished d-sum is parked here.
      if (state_r == ST_M2) begin
        acc_d_r <= mac_acc_s;
      end else begin
        acc_d_r <= acc_d_r;
      end
      if (state_r == ST_OUT) begin
        id_r <= res_d_s;
        iq_r <= res_q_s;
      end else begin
        id_r <= id_r;
        iq_r <= iq_r;
      end
    end
  end

  assign bus.oP_done = done_r;
  assign bus.oBusy   = busy_r;
  assign bus.oId     = id_r;
  assign bus.oIq     = iq_r;

endmodule

// File: tb/tb_park_transform.sv
// Directed self-checking bench for park_transform with hand-computed Q1.15 results.
module tb_park_transform;

  logic iClk;
  logic iRst_n;
  int   errors;
  int   checks;

  park_transform_if bus ();

  park_transform dut (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .bus    (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

`ifdef FOC_PARK_SAT_EN
  localparam int OV_ID = 32767;
`else
  localparam int OV_ID = -19198;
`endif

  task automatic tick();
    @(posedge iClk);
    @(negedge iClk);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic set_ops(input int s, input int c, input int a, input int b);
    bus.iSin    = 16'(s);
    bus.iCos    = 16'(c);
    bus.iIalpha = 16'(a);
    bus.iIbeta  = 16'(b);
  endtask

  // One transform with a single-cycle enable pulse; checks latency, width and results.
  task automatic run_xform(input string tag, input int s, input int c, input int a, input int b,
                           input int exp_id, input int exp_iq);
    logic early;
    set_ops(s, c, a, b);
    bus.iP_en = 1'b1;
    tick();
    chk({tag, "_busy_k"}, 32'(bus.oBusy), 32'sd1);
    bus.iP_en = 1'b0;
    early = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (bus.oP_done) early = 1'b1;
    end
    chk({tag, "_no_early_done"}, 32'(early), 32'sd0);
    tick();
    chk({tag, "_done_k5"}, 32'(bus.oP_done), 32'sd1);
    chk({tag, "_id"}, 32'(bus.oId), exp_id);
    chk({tag, "_iq"}, 32'(bus.oIq), exp_iq);
    chk({tag, "_busy_k5"}, 32'(bus.oBusy), 32'sd0);
    tick();
    chk({tag, "_done_k6"}, 32'(bus.oP_done), 32'sd0);
  endtask

  initial begin
    int   cnt;
    logic signed [15:0] cap_id, cap_iq;
    logic hold;
    errors = 0;
    checks = 0;
    iRst_n = 1'b0;
    bus.iP_en = 1'b0;
    set_ops(0, 0, 0, 0);
    repeat (3) tick();
    chk("rst_id", 32'(bus.oId), 32'sd0);
    chk("rst_iq", 32'(bus.oIq), 32'sd0);
    chk("rst_done", 32'(bus.oP_done), 32'sd0);
    chk("rst_busy", 32'(bus.oBusy), 32'sd0);
    iRst_n = 1'b1;
    tick();

    run_xform("ident", 0, 32767, 1000, -500, 999, -500);
    run_xform("deg90", 32767, 0, 2000, 2000, 1999, -2000);
    run_xform("ovf", 23170, 23170, 32767, 32767, OV_ID, 0);

    // Level held high with an extra edge at k+3; operands change after k.
    set_ops(0, 32767, 1000, -500);
    bus.iP_en = 1'b1;
    tick();
    set_ops(32767, 0, 2000, 2000);
    tick();
    bus.iP_en = 1'b0;
    tick();
    bus.iP_en = 1'b1;
    cnt = 0;
    cap_id = 16'sd0;
    cap_iq = 16'sd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.oP_done) begin
        cnt++;
        cap_id = bus.oId;
        cap_iq = bus.oIq;
      end
    end
    bus.iP_en = 1'b0;
    tick();
    chk("level_done_count", cnt, 32'sd1);
    chk("level_id", 32'(cap_id), 32'sd999);
    chk("level_iq", 32'(cap_iq), -32'sd500);

    // Reset asserted while the FSM is in M2.
    set_ops(32767, 0, 2000, 2000);
    bus.iP_en = 1'b1;
    tick();
    bus.iP_en = 1'b0;
    tick();
    tick();
    iRst_n = 1'b0;
    #1;
    chk("midrst_id", 32'(bus.oId), 32'sd0);
    chk("midrst_iq", 32'(bus.oIq), 32'sd0);
    chk("midrst_busy", 32'(bus.oBusy), 32'sd0);
    chk("midrst_done", 32'(bus.oP_done), 32'sd0);
    tick();
    tick();
    iRst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.oP_done) cnt++;
    end
    chk("midrst_no_done", cnt, 32'sd0);
    chk("midrst_idle", 32'(bus.oBusy), 32'sd0);
    run_xform("post_rst", 32767, 0, 2000, 2000, 1999, -2000);

    // Back-to-back: second start sampled at k+6, done at k+11.
    set_ops(23170, 23170, 32767, 32767);
    bus.iP_en = 1'b1;
    tick();
    bus.iP_en = 1'b0;
    repeat (4) tick();
    tick();
    chk("b2b_done1", 32'(bus.oP_done), 32'sd1);
    chk("b2b_id1", 32'(bus.oId), OV_ID);
    chk("b2b_iq1", 32'(bus.oIq), 32'sd0);
    set_ops(0, 32767, 1000, -500);
    bus.iP_en = 1'b1;
    tick();
    chk("b2b_busy_k6", 32'(bus.oBusy), 32'sd1);
    bus.iP_en = 1'b0;
    hold = 1'b1;
    if (bus.oP_done || (32'(bus.oId) != OV_ID) || (bus.oIq != 16'sd0)) hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.oP_done || (32'(bus.oId) != OV_ID) || (bus.oIq != 16'sd0)) hold = 1'b0;
    end
    chk("b2b_hold", 32'(hold), 32'sd1);
    tick();
    chk("b2b_done2", 32'(bus.oP_done), 32'sd1);
    chk("b2b_id2", 32'(bus.oId), 32'sd999);
    chk("b2b_iq2", 32'(bus.oIq), -32'sd500);
    tick();
    chk("b2b_done2_end", 32'(bus.oP_done), 32'sd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
